// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a single-ported data memory.
// Stores drain in FIFO order when no load owns the port; loads forward from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_st_valid,
  input  logic        i_ld_valid,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_fence,
  input  logic        i_dmem_hold,
  input  logic [31:0] i_dmem_rd,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_sb_empty,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_a,
  output logic [31:0] o_dmem_wd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_drain;
  logic            w_accept;
  entry_t          w_head_entry;

  assign w_head_entry = r_mem[r_head];
  assign w_full       = (r_count == CW'(DEPTH));
  // Loads always own the memory port; the external hold only freezes draining.
  assign w_drain      = (r_count != '0) & ~i_ld_valid & ~i_dmem_hold;
  assign w_accept     = i_st_valid & (~w_full | w_drain);

  assign o_stall    = (i_st_valid & w_full & ~w_drain) | (i_fence & (r_count != '0));
  assign o_sb_empty = (r_count == '0);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    o_dmem_wd = w_head_entry.data;
    o_dmem_a  = i_addr;
    o_dmem_we = 1'b0;
    if (!i_ld_valid && w_drain) begin
      o_dmem_a  = w_head_entry.addr;
      o_dmem_we = 1'b1;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    o_ld_data = i_dmem_rd;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_mem[r_head + PW'(i)].addr[31:2] == i_addr[31:2]))
        o_ld_data = r_mem[r_head + PW'(i)].data;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_drain)  r_head <= r_head + 1'b1;
      case ({w_accept, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: entry storage is not reset; an entry is only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_tail] <= '{addr: i_addr, data: i_wdata};
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer: expected memory writes are queued as stores are
// driven and popped by a write monitor; each scenario also checks outputs inline.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        ld_valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        fence;
  logic        dmem_hold;
  logic [31:0] dmem_rd;
  logic [31:0] ld_data;
  logic        stall;
  logic        sb_empty;
  logic        dmem_we;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign dmem_rd = rd_pattern(dmem_a);

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .i_reset    (reset),
    .i_st_valid (st_valid),
    .i_ld_valid (ld_valid),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_fence    (fence),
    .i_dmem_hold(dmem_hold),
    .i_dmem_rd  (dmem_rd),
    .o_ld_data  (ld_data),
    .o_stall    (stall),
    .o_sb_empty (sb_empty),
    .o_dmem_we  (dmem_we),
    .o_dmem_a   (dmem_a),
    .o_dmem_wd  (dmem_wd)
  );

  // Every memory write must be the oldest still-expected store.
  always @(negedge clk) begin
    if (dmem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got a=%h d=%h, required no write", dmem_a, dmem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (dmem_a !== e.a || dmem_wd !== e.d) begin
          errors++;
          $display("FAIL write_order: got a=%h d=%h, required a=%h d=%h", dmem_a, dmem_wd, e.a, e.d);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 1'b0; ld_valid = 1'b0; fence = 1'b0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; ld_valid = 1'b0; addr = a; wdata = d;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb_empty !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (sb_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain_timeout: sb_empty=%b, required 1 within 20 cycles", name, sb_empty);
    end
  endtask

  task automatic test_reset();
    idle(); dmem_hold = 1'b0; reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    fence = 1'b1; ld_valid = 1'b1; addr = 32'h0000_1234;
    #1;
    checks++;
    if (sb_empty !== 1'b1 || dmem_we !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: empty=%b we=%b stall=%b, required 1 0 0", sb_empty, dmem_we, stall);
    end
    checks++;
    if (ld_data !== rd_pattern(32'h0000_1234)) begin
      errors++;
      $display("FAIL reset_ld_data: got %h, required %h", ld_data, rd_pattern(32'h0000_1234));
    end
    idle();
  endtask

  task automatic test_single_store();
    cyc();
    store(32'h10, 32'hDEADBEEF);
    expect_write(32'h10, 32'hDEADBEEF);
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: stall=%b we=%b, required 0 0", stall, dmem_we);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (dmem_we !== 1'b1 || dmem_a !== 32'h10 || dmem_wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: we=%b a=%h wd=%h, required 1 00000010 deadbeef", dmem_we, dmem_a, dmem_wd);
    end
    cyc();
    checks++;
    if (sb_empty !== 1'b1 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: empty=%b we=%b, required 1 0", sb_empty, dmem_we);
    end
  endtask

  task automatic test_forward();
    dmem_hold = 1'b1;
    cyc(); store(32'h20, 32'h1111); expect_write(32'h20, 32'h1111);
    cyc(); store(32'h20, 32'h2222); expect_write(32'h20, 32'h2222);
    cyc(); idle(); ld_valid = 1'b1; addr = 32'h20;
    #1;
    checks++;
    if (ld_data !== 32'h2222) begin
      errors++;
      $display("FAIL fwd_youngest: got %h, required 00002222", ld_data);
    end
    cyc(); ld_valid = 1'b1; addr = 32'h24;
    #1;
    checks++;
    if (ld_data !== rd_pattern(32'h24) || dmem_a !== 32'h24 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL fwd_miss: ld=%h a=%h we=%b, required %h 00000024 0", ld_data, dmem_a, dmem_we, rd_pattern(32'h24));
    end
    cyc(); idle(); dmem_hold = 1'b0;
    wait_empty("fwd");
  endtask

  task automatic test_full();
    dmem_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      store(32'(i * 4), 32'h100 + 32'(i));
      expect_write(32'(i * 4), 32'h100 + 32'(i));
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL full_fill%0d: stall=%b, required 0", i, stall);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      store(32'h40, 32'h4040);
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL full_reject%0d: stall=%b, required 1", k, stall);
      end
    end
    cyc();
    dmem_hold = 1'b0;
    expect_write(32'h40, 32'h4040);
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_we !== 1'b1 || dmem_a !== 32'h0) begin
      errors++;
      $display("FAIL full_accept_drain: stall=%b we=%b a=%h, required 0 1 00000000", stall, dmem_we, dmem_a);
    end
    cyc();
    dmem_hold = 1'b1;
    store(32'h44, 32'h4444);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL full_still4: stall=%b, required 1", stall);
    end
    cyc(); idle(); dmem_hold = 1'b0;
    wait_empty("full");
  endtask

  task automatic test_load_priority();
    dmem_hold = 1'b1;
    cyc(); store(32'h30, 32'hAAAA_0030); expect_write(32'h30, 32'hAAAA_0030);
    cyc(); store(32'h34, 32'hAAAA_0034); expect_write(32'h34, 32'hAAAA_0034);
    for (int k = 0; k < 3; k++) begin
      cyc(); idle(); dmem_hold = 1'b0; ld_valid = 1'b1; addr = 32'h80;
      #1;
      checks++;
      if (dmem_we !== 1'b0 || dmem_a !== 32'h80 || stall !== 1'b0 || ld_data !== rd_pattern(32'h80)) begin
        errors++;
        $display("FAIL ld_owns_port%0d: we=%b a=%h stall=%b ld=%h, required 0 00000080 0 %h",
                 k, dmem_we, dmem_a, stall, ld_data, rd_pattern(32'h80));
      end
    end
    cyc(); idle();
    #1;
    checks++;
    if (dmem_we !== 1'b1 || dmem_a !== 32'h30) begin
      errors++;
      $display("FAIL ld_drain_resume: we=%b a=%h, required 1 00000030", dmem_we, dmem_a);
    end
    wait_empty("ld");
  endtask

  task automatic test_back_to_back();
    dmem_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      store(32'h200 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      expect_write(32'h200 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall%0d: stall=%b, required 0", i, stall);
      end
    end
    cyc(); idle();
    wait_empty("b2b");
  endtask

  task automatic test_fence();
    logic [31:0] fa [3];
    fa[0] = 32'h50; fa[1] = 32'h54; fa[2] = 32'h58;
    dmem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); store(fa[i], 32'hF000_0000 + 32'(i)); expect_write(fa[i], 32'hF000_0000 + 32'(i));
    end
    cyc(); idle(); dmem_hold = 1'b0; fence = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 1'b1 || dmem_we !== 1'b1 || dmem_a !== fa[i]) begin
        errors++;
        $display("FAIL fence_cycle%0d: stall=%b we=%b a=%h, required 1 1 %h", i, stall, dmem_we, dmem_a, fa[i]);
      end
      cyc();
    end
    #1;
    checks++;
    if (stall !== 1'b0 || sb_empty !== 1'b1) begin
      errors++;
      $display("FAIL fence_release: stall=%b empty=%b, required 0 1", stall, sb_empty);
    end
    fence = 1'b0;
  endtask

  task automatic test_reset_mid();
    dmem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); store(32'h60 + 32'(i * 4), 32'hE000_0000 + 32'(i));
    end
    cyc(); idle(); reset = 1'b1;
    cyc(); reset = 1'b0; dmem_hold = 1'b0;
    #1;
    checks++;
    if (sb_empty !== 1'b1 || dmem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: empty=%b we=%b, required 1 0", sb_empty, dmem_we);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (dmem_we !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nowrite%0d: we=%b, required 0", k, dmem_we);
      end
    end
    ld_valid = 1'b1; addr = 32'h64;
    #1;
    checks++;
    if (ld_data !== rd_pattern(32'h64)) begin
      errors++;
      $display("FAIL rstmid_load: got %h, required %h", ld_data, rd_pattern(32'h64));
    end
    cyc(); idle();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_forward();
    test_full();
    test_load_priority();
    test_back_to_back();
    test_fence();
    test_reset_mid();
    cyc(); cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_outstanding: %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
